alu_seq_exec: RTL
=================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  operation request, sampled only while ready=1.
REQ-005 The block SHALL have port Funct  input  6  ALU function code from the ALU control decoder.
REQ-006 The block SHALL have ports src1 and src2  input  DATA_W  each, meaning operands.
REQ-007 The block SHALL have port ready  output  1  high in IDLE, meaning start is accepted.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port result  output  DATA_W  operation result, held until the next done.
REQ-010 The block SHALL have port zero  output  1  high when result == 0, updated with done.
REQ-011 The block SHALL have port err  output  1  illegal Funct flag, valid with done.

Function
REQ-012 The block SHALL decode Funct 001001=ADD, 001010=SUB, 010001=MUL, 100001=SRL; every other code SHALL be illegal.
REQ-013 The block SHALL implement FSM states IDLE, MUL, SHR, FIN; start&ready in IDLE SHALL latch Funct, src1 and src2.
REQ-014 On acceptance of ADD, SUB or an illegal code, IDLE SHALL go to FIN.
REQ-015 On acceptance, MUL SHALL go to state MUL and SRL SHALL go to state SHR.
REQ-016 In FIN the block SHALL assert done for exactly one cycle and SHALL return to IDLE on the next edge.
REQ-017 ADD and SUB SHALL be mod 2^DATA_W and SHALL produce done 1 cycle after the accepting edge.
REQ-018 MUL SHALL be iterative shift-add, one multiplier bit per cycle, for DATA_W cycles; result SHALL be the low DATA_W bits of the product; done SHALL assert DATA_W+1 cycles after acceptance.
REQ-019 SRL SHALL be logical and SHALL shift one bit per cycle by src2[log2(DATA_W)-1:0].
REQ-020 SRL with shift count n SHALL produce done n+1 cycles after acceptance; n=0 SHALL give done 1 cycle after acceptance with result=src1.
REQ-021 An illegal code SHALL give done with err=1 and result=0; legal codes SHALL give err=0.
REQ-022 ready SHALL be 0 in states MUL, SHR and FIN; start while ready=0 SHALL be ignored, with no queuing.
REQ-023 Input changes after acceptance SHALL NOT affect the operation in flight.
REQ-024 start held high continuously SHALL launch a new operation in the first IDLE cycle after each done.
REQ-025 result, zero and err SHALL change only on the edge that raises done.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, ready=1, done=0, result=0, zero=1, err=0, from any state.
REQ-027 rst asserted mid-MUL or mid-SRL SHALL abort the operation with no done pulse; start is ignored while rst=1.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined SHALL compile in the MUL datapath and the MUL state.
REQ-029 Without ALU_SEQ_MUL_EN, Funct 010001 SHALL be treated as illegal: err=1, 1-cycle latency, and no multiplier logic.

Verification
REQ-030 The bench SHALL cover: reset, then ADD with src1=5, src2=7 -> done one cycle after acceptance, result=12, zero=0, err=0.
REQ-031 The bench SHALL cover: SUB with 9, 9 -> result=0, zero=1; SUB with 0, 1 -> result=0xFFFFFFFF.
REQ-032 The bench SHALL cover: with MUL_EN, MUL with 0x10001, 0x10001 -> done 33 cycles after acceptance, result=0x00020001, ready=0 throughout; without MUL_EN, same stimulus -> err=1 after 1 cycle.
REQ-033 The bench SHALL cover: SRL with 0x80000000, 31 -> result=1 after 32 cycles; SRL with shift 0 -> result=src1 after 1 cycle.
REQ-034 The bench SHALL cover: Funct=111111 -> err=1, result=0; start pulsed mid-SRL -> ignored, with exactly one done.
REQ-035 The bench SHALL cover: rst asserted at cycle 10 of a MUL -> no done, next cycle ready=1 and result=0, and a following ADD completes normally.

Source files
------------

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU executing ADD, SUB, MUL (iterative shift-add)
// and SRL (one bit per cycle) behind a start/ready/done handshake.
// Optional feature macro: ALU_SEQ_MUL_EN compiles in the MUL state and the
// shift-add multiplier; without it the MUL code is reported as illegal.
module alu_seq_exec #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err
);

    localparam int SHW = $clog2(DATA_W);

    localparam logic [5:0] F_ADD = 6'b001001;
    localparam logic [5:0] F_SUB = 6'b001010;
    localparam logic [5:0] F_SRL = 6'b100001;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [5:0] F_MUL = 6'b010001;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        MUL  = 2'd1,
`endif
        SHR  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state;
    logic [SHW-1:0]    cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [SHW-1:0]    shamt;

    // Result flag derivation kept in one place so every completion path agrees.
    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == '0);
    endfunction

    // Wrap-around arithmetic: the carry/borrow out of the top bit is dropped.
    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    function automatic logic [DATA_W-1:0] sub_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a - b;
    endfunction

    assign sum       = add_wrap(src1, src2);
    assign diff      = sub_wrap(src1, src2);
    assign shamt     = src2[SHW-1:0];
    assign shreg_nxt = shreg >> 1;

`ifdef ALU_SEQ_MUL_EN
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;

    // One shift-add step: add the (already shifted) multiplicand when the
    // current multiplier LSB is set; only the low DATA_W product bits are kept.
    assign acc_nxt = add_wrap(acc, mplier[0] ? mcand : '0);
`endif

    // Control FSM with registered handshake and result outputs; operands are
    // captured into the working registers on acceptance so later input changes
    // cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        ready <= 1'b0;
                        case (Funct)
                            F_ADD: begin
                                result <= sum;
                                zero   <= is_zero(sum);
                                err    <= 1'b0;
                                done   <= 1'b1;
                                state  <= FIN;
                            end
                            F_SUB: begin
                                result <= diff;
                                zero   <= is_zero(diff);
                                err    <= 1'b0;
                                done   <= 1'b1;
                                state  <= FIN;
                            end
`ifdef ALU_SEQ_MUL_EN
                            F_MUL: begin
                                mcand  <= src1;
                                mplier <= src2;
                                acc    <= '0;
                                cnt    <= SHW'(DATA_W - 1);
                                state  <= MUL;
                            end
`endif
                            F_SRL: begin
                                // A zero shift count finishes immediately.
                                if (shamt == '0) begin
                                    result <= src1;
                                    zero   <= is_zero(src1);
                                    err    <= 1'b0;
                                    done   <= 1'b1;
                                    state  <= FIN;
                                end else begin
                                    shreg <= src1;
                                    cnt   <= shamt - 1'b1;
                                    state <= SHR;
                                end
                            end
                            default: begin
                                result <= '0;
                                zero   <= 1'b1;
                                err    <= 1'b1;
                                done   <= 1'b1;
                                state  <= FIN;
                            end
                        endcase
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= acc_nxt;
                        zero   <= is_zero(acc_nxt);
                        err    <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
`endif
                SHR: begin
                    shreg <= shreg_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= shreg_nxt;
                        zero   <= is_zero(shreg_nxt);
                        err    <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
